execute_writeback_unit: RTL and testbench
=========================================

Name: execute_writeback_unit

Overview:
- Execute/writeback stage directly downstream of the fetch/decode stage in Processorv1; consumes decoded fields (type, rs, rd, funct, rt, imm15).
- Owns the 64x32 architectural register file; reads operands, runs the ALU or a 32-cycle iterative multiply, and writes back rd.
- Valid/ready handshake toward decode; one instruction in flight.

Parameters:
- DATA_W, 32, datapath and register width.
- REG_AW, 6, register index width (64 registers).

Ports:
- clk  in  1  clock, rising edge.
- clkreset  in  1  asynchronous, active-high reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  unit can accept an instruction.
- instr_type  in  1  0 = register form (B = reg[rt]); 1 = immediate form (B = sign-extended imm15).
- rs  in  6  source A index.
- rt  in  6  source B index (type 0 only).
- rd  in  6  destination index.
- funct  in  4  operation select.
- imm15  in  15  immediate (type 1 only).
- result_valid  out  1  one-cycle pulse when a result is written.
- result_rd  out  6  destination of the current result.
- result_data  out  32  value written.
- illegal_op  out  1  one-cycle pulse for a reserved funct.
- dbg_addr  in  6  debug read index.
- dbg_data  out  32  combinational reg[dbg_addr]; reads 0 when dbg_addr = 0.

Behaviour:
- Reset (async, while clkreset = 1): all 64 registers = 0; state = IDLE; in_ready, result_valid, illegal_op = 0; result_rd = 0; result_data = 0.
- States: IDLE, MUL, WB.
- in_ready = 1 only in IDLE and clkreset = 0. A transfer happens on a rising edge with in_valid & in_ready.
- On accept: A = reg[rs]; B = type ? sext(imm15) : reg[rt]; reg[0] always reads 0. Capture rd and funct.
- funct 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA. For shifts, shamt = B[4:0].
- funct 8 SLT (signed, result 1/0), 9 SLTU (unsigned).
- funct 10 MUL: low 32 bits of A*B.
- funct 11-15: reserved.
- Arithmetic wraps mod 2^32; no overflow flag.
- Single-cycle ops: accept edge N registers the result and moves to WB. During cycle N..N+1, result_valid = 1 with result_rd and result_data. At edge N+1, reg[rd] is written and the state returns to IDLE.
  - Throughput is one instruction per 2 cycles.
- MUL: accept edge N moves to MUL. A radix-2 shift-add runs for 32 cycles, one multiplier bit per edge, with a 6-bit iteration counter. After the 32nd iteration edge the state moves to WB; result_valid is high in the following cycle and the write occurs at edge N+33.
- Reserved funct: the accept edge moves to WB with the write suppressed. illegal_op pulses for one WB cycle; result_valid stays 0.
- rd = 0: the write is discarded (reg[0] stays 0). result_valid still pulses, with result_data = computed value.
- No RAW hazard: the next accept cannot occur before the WB edge, so it reads updated values.
- result_data and result_rd hold their last values outside WB.
- Reset asserted mid-MUL or in WB aborts the operation: no writeback, no pulse, and all registers are cleared.
- in_valid while in_ready = 0 is ignored. Decode must hold the instruction stable until accepted.

Test Plan:
- Reset, then type1 ADD rs=0 rd=1 imm15=5 -> result_valid for one cycle, result_rd=1, result_data=5; dbg_addr=1 reads 5 afterwards; in_ready low for exactly 1 cycle.
- Type1 ADD rd=2 imm15=0x7FFF (=-1 sign-extended), then type0 SUB rd=3 rs=1 rt=2 -> r2=0xFFFFFFFF, r3=6. Type0 SLT rd=4 rs=2 rt=1 -> 1; SLTU same operands -> 0.
- Type1 SRA rs=2 imm15=4 -> 0xFFFFFFFF; load r5=0x80000000 via ADD then SLL, then SRL rs=5 shamt 31 -> 1.
- Type0 MUL r1(5)*r2(-1) rd=6 -> in_ready low for 33 cycles, result 0xFFFFFFFB at edge N+33; in_valid held during MUL is not accepted.
- Type1 ADD rd=0 imm15=9 -> result_valid pulses with data 9; dbg_addr=0 still reads 0. funct=12 -> illegal_op pulse, no result_valid, registers unchanged.
- Start MUL, assert clkreset at iteration 10 -> in_ready=0 while reset is held, all registers 0, no result_valid. After release, in_ready=1 and state IDLE.

Source files
------------

// File: rtl/execute_writeback_unit.sv
// execute_writeback_unit: register file, ALU and iterative multiplier with single-entry writeback
module execute_writeback_unit #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 6
) (
  input  logic              clk,
  input  logic              clkreset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              instr_type,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic [REG_AW-1:0] rd,
  input  logic [3:0]        funct,
  input  logic [14:0]       imm15,
  output logic              result_valid,
  output logic [REG_AW-1:0] result_rd,
  output logic [DATA_W-1:0] result_data,
  output logic              illegal_op,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  localparam int NREG = 1 << REG_AW;
  typedef enum logic [1:0] {IDLE, MUL, WB} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rf_d [NREG];
  logic [DATA_W-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [REG_AW-1:0] res_rd_q, res_rd_d;
  logic [5:0]        cnt_q, cnt_d;
  logic              ill_q, ill_d;
  logic [DATA_W-1:0] op_a, op_b, alu;
  logic [4:0]        shamt;
  assign op_a     = (rs == '0) ? '0 : rf_q[rs];
  assign op_b     = instr_type ? {{(DATA_W-15){imm15[14]}}, imm15} : ((rt == '0) ? '0 : rf_q[rt]);
  assign shamt    = op_b[4:0];
  assign dbg_data = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];
  assign in_ready     = (state_q == IDLE) && !clkreset;
  assign result_valid = (state_q == WB) && !ill_q;
  assign illegal_op   = (state_q == WB) && ill_q;
  assign result_rd    = res_rd_q;
  assign result_data  = res_data_q;
  // single-cycle ALU on the operands presented at accept time
  always_comb begin
    alu = '0;
    case (funct)
      4'd0: alu = op_a + op_b;
      4'd1: alu = op_a - op_b;
      4'd2: alu = op_a & op_b;
      4'd3: alu = op_a | op_b;
      4'd4: alu = op_a ^ op_b;
      4'd5: alu = op_a << shamt;
      4'd6: alu = op_a >> shamt;
      4'd7: alu = $signed(op_a) >>> shamt;
      4'd8: alu = {{(DATA_W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      4'd9: alu = {{(DATA_W-1){1'b0}}, op_a < op_b};
      default: alu = '0;
    endcase
  end
  // control: accept in IDLE, shift-add in MUL, commit to the register file on the WB edge
  always_comb begin
    state_d    = state_q;
    rf_d       = rf_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ill_d      = ill_q;
    res_rd_d   = res_rd_q;
    res_data_d = res_data_q;
    case (state_q)
      IDLE: if (in_valid) begin
        ill_d = funct > 4'd10;
        if (funct == 4'd10) begin
          mcand_d  = op_a;
          mplier_d = op_b;
          acc_d    = '0;
          cnt_d    = '0;
          res_rd_d = rd;
          state_d  = MUL;
        end else begin
          res_rd_d   = ill_d ? res_rd_q : rd;
          res_data_d = ill_d ? res_data_q : alu;
          state_d    = WB;
        end
      end
      MUL: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 6'd1;
        res_data_d = (cnt_q == 6'd31) ? acc_d : res_data_q;
        state_d    = (cnt_q == 6'd31) ? WB : MUL;
      end
      WB: begin
        if (!ill_q && res_rd_q != '0) rf_d[res_rd_q] = res_data_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and register-file flops; reset aborts any operation in flight
  always_ff @(posedge clk or posedge clkreset) begin
    if (clkreset) begin
      state_q    <= IDLE;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ill_q      <= 1'b0;
      res_rd_q   <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rf_q       <= rf_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ill_q      <= ill_d;
      res_rd_q   <= res_rd_d;
      res_data_q <= res_data_d;
    end
  end
endmodule

// File: tb/tb_execute_writeback_unit.sv
// tb_execute_writeback_unit: scoreboard bench with directed instructions
module tb_execute_writeback_unit;
  logic        clk = 0, clkreset = 1, in_valid = 0, instr_type = 0;
  logic [5:0]  rs = 0, rt = 0, rd = 0, dbg_addr = 0;
  logic [3:0]  funct = 0;
  logic [14:0] imm15 = 0;
  logic        in_ready, result_valid, illegal_op;
  logic [5:0]  result_rd;
  logic [31:0] result_data, dbg_data;
  typedef struct {logic ill; logic [5:0] rd; logic [31:0] data;} exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0;

  execute_writeback_unit dut (
    .clk(clk), .clkreset(clkreset), .in_valid(in_valid), .in_ready(in_ready),
    .instr_type(instr_type), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm15(imm15),
    .result_valid(result_valid), .result_rd(result_rd), .result_data(result_data),
    .illegal_op(illegal_op), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // monitor: every output pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (result_valid || illegal_op) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: valid=%0b illegal=%0b rd=%0d data=0x%08h", result_valid, illegal_op, result_rd, result_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mon_valid", {31'b0, result_valid}, {31'b0, !e.ill});
        chk("mon_illegal", {31'b0, illegal_op}, {31'b0, e.ill});
        if (!e.ill) begin
          chk("mon_rd", {26'b0, result_rd}, {26'b0, e.rd});
          chk("mon_data", result_data, e.data);
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic issue(input logic t, input logic [5:0] s, input logic [5:0] b, input logic [5:0] d,
                       input logic [3:0] f, input logic [14:0] im, input logic e_ill,
                       input logic [31:0] e_data, input bit push, input bit hold);
    exp_t e;
    wait_ready();
    instr_type = t; rs = s; rt = b; rd = d; funct = f; imm15 = im; in_valid = 1;
    e.ill = e_ill; e.rd = d; e.data = e_data;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) in_valid = 0;
  endtask

  task automatic dbg(input logic [5:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    chk($sformatf("dbg_r%0d", a), dbg_data, exp);
  endtask

  initial begin
    int n;
    #1;
    chk("reset_in_ready", {31'b0, in_ready}, 0);
    repeat (3) @(posedge clk);
    #1 clkreset = 0;
    @(negedge clk);
    chk("reset_valid", {31'b0, result_valid}, 0);
    chk("reset_rd", {26'b0, result_rd}, 0);
    chk("reset_data", result_data, 0);
    chk("idle_in_ready", {31'b0, in_ready}, 1);
    dbg(1, 0);
    issue(1, 0, 0, 1, 0, 15'd5, 0, 32'd5, 1, 0);
    @(negedge clk);
    chk("wb_in_ready_low", {31'b0, in_ready}, 0);
    @(negedge clk);
    chk("after_wb_in_ready", {31'b0, in_ready}, 1);
    dbg(1, 5);
    issue(1, 0, 0, 2, 0, 15'h7FFF, 0, 32'hFFFFFFFF, 1, 0);
    issue(0, 1, 2, 3, 1, 0, 0, 32'd6, 1, 0);
    issue(0, 2, 1, 4, 8, 0, 0, 32'd1, 1, 0);
    issue(0, 2, 1, 7, 9, 0, 0, 32'd0, 1, 0);
    issue(1, 2, 0, 8, 7, 15'd4, 0, 32'hFFFFFFFF, 1, 0);
    issue(1, 0, 0, 5, 0, 15'd1, 0, 32'd1, 1, 0);
    issue(1, 5, 0, 5, 5, 15'd31, 0, 32'h80000000, 1, 0);
    issue(1, 5, 0, 9, 6, 15'd31, 0, 32'd1, 1, 0);
    issue(1, 2, 0, 10, 2, 15'h00F0, 0, 32'h000000F0, 1, 0);
    issue(0, 1, 3, 11, 3, 0, 0, 32'd7, 1, 0);
    issue(0, 1, 3, 12, 4, 0, 0, 32'd3, 1, 0);
    wait_ready();
    dbg(2, 32'hFFFFFFFF);
    dbg(3, 6);
    dbg(5, 32'h80000000);
    issue(0, 1, 2, 6, 10, 0, 0, 32'hFFFFFFFB, 1, 1);
    n = 0;
    forever begin
      @(negedge clk);
      if (n == 20) in_valid = 0;
      if (in_ready || n >= 100) break;
      n++;
    end
    in_valid = 0;
    chk("mul_busy_cycles", n, 33);
    dbg(6, 32'hFFFFFFFB);
    issue(1, 0, 0, 0, 0, 15'd9, 0, 32'd9, 1, 0);
    wait_ready();
    dbg(0, 0);
    issue(0, 1, 3, 1, 12, 0, 1, 0, 1, 0);
    wait_ready();
    dbg(1, 5);
    dbg(3, 6);
    issue(0, 1, 2, 6, 10, 0, 0, 0, 0, 0);
    repeat (10) @(posedge clk);
    #2 clkreset = 1;
    #1;
    chk("rst_mul_in_ready", {31'b0, in_ready}, 0);
    chk("rst_mul_valid", {31'b0, result_valid}, 0);
    for (int i = 1; i < 13; i++) dbg(i[5:0], 0);
    repeat (3) @(posedge clk);
    #1 clkreset = 0;
    @(negedge clk);
    chk("rst_release_in_ready", {31'b0, in_ready}, 1);
    chk("rst_release_data", result_data, 0);
    repeat (40) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
